// File: rtl/adc_sample_delay.sv
// adc_sample_delay: run-time-programmable sample delay line over a circular buffer.
// Optional range flag ovr_out when ADC_SAMPLE_DELAY_OVR_EN is defined.
module adc_sample_delay #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] adc_in,
  input  logic [AW-1:0]    delay_sel,
  output logic             out_valid,
`ifdef ADC_SAMPLE_DELAY_OVR_EN
  output logic             ovr_out,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             filling,
  output logic [AW-1:0]    delay_cur
);
`ifdef ADC_SAMPLE_DELAY_OVR_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_nxt;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_data, rd_data;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill_cnt, fill_nxt;
  logic          change, strobe;
  assign change = flush || (delay_sel != delay_cur);
  // D = delay_cur+1; with D = DEPTH this lands on the slot about to be overwritten
  assign rd_ptr = wr_ptr - delay_cur - AW'(1);
  assign rd_data = mem[rd_ptr];
  assign filling = (state == FILL);
`ifdef ADC_SAMPLE_DELAY_OVR_EN
  assign wr_data = {(adc_in == '0) || (adc_in == '1), adc_in};
`else
  assign wr_data = adc_in;
`endif
  always_comb begin
    state_nxt = state;
    fill_nxt = fill_cnt;
    strobe = 1'b0;
    if (change) begin
      state_nxt = FILL;
      fill_nxt = (AW+1)'(in_valid);
    end else if (in_valid) begin
      strobe = (state == RUN) || (fill_cnt == {1'b0, delay_cur} + (AW+1)'(1));
      state_nxt = strobe ? RUN : state;
      fill_nxt = strobe ? fill_cnt : fill_cnt + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (in_valid) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      fill_cnt <= '0;
      delay_cur <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
`ifdef ADC_SAMPLE_DELAY_OVR_EN
      ovr_out <= 1'b0;
`endif
    end else begin
      if (in_valid) wr_ptr <= wr_ptr + AW'(1);
      fill_cnt <= fill_nxt;
      delay_cur <= delay_sel;
      out_valid <= strobe;
      if (strobe) begin
        out_data <= rd_data[WIDTH-1:0];
`ifdef ADC_SAMPLE_DELAY_OVR_EN
        ovr_out <= rd_data[WIDTH];
`endif
      end
    end
endmodule

// File: tb/tb_adc_sample_delay.sv
// tb_adc_sample_delay: directed self-checking bench for adc_sample_delay (optionally ADC_SAMPLE_DELAY_OVR_EN).
module tb_adc_sample_delay;
  localparam int WIDTH = 14;
  localparam int AW = 6;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [WIDTH-1:0] adc_in = '0, out_data;
  logic [AW-1:0] delay_sel = '0, delay_cur;
  logic out_valid, filling;
  int n_chk = 0, n_fail = 0;
  int k, last;
`ifdef ADC_SAMPLE_DELAY_OVR_EN
  logic ovr_out;
`endif
  adc_sample_delay #(.WIDTH(WIDTH), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .adc_in(adc_in),
    .delay_sel(delay_sel), .out_valid(out_valid),
`ifdef ADC_SAMPLE_DELAY_OVR_EN
    .ovr_out(ovr_out),
`endif
    .out_data(out_data), .filling(filling), .delay_cur(delay_cur)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input int d);
    in_valid = v;
    adc_in = WIDTH'(d);
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 55);
      chk("rst_ov", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_fill", filling, 1);
      chk("rst_dcur", delay_cur, 0);
`ifdef ADC_SAMPLE_DELAY_OVR_EN
      chk("rst_ovr", ovr_out, 0);
`endif
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i);
      chk("d1_ov", out_valid, (i > 0) ? 1 : 0);
      chk("d1_fill", filling, (i > 0) ? 0 : 1);
      if (i > 0) chk("d1_data", out_data, i - 1);
    end
    last = 8;
    delay_sel = 3;
    cyc(1'b0, 0);
    chk("d4_fill", filling, 1);
    chk("d4_dcur", delay_cur, 3);
    chk("d4_ov0", out_valid, 0);
    chk("d4_hold", out_data, last);
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (i % 3 != 1) begin
        cyc(1'b1, k);
        chk("d4_ov", out_valid, (k >= 4) ? 1 : 0);
        if (k >= 4) last = k - 4;
        k++;
      end else begin
        cyc(1'b0, 999);
        chk("d4_idle_ov", out_valid, 0);
      end
      chk("d4_data", out_data, last);
    end
    delay_sel = 63;
    cyc(1'b0, 0);
    chk("dmax_fill", filling, 1);
    chk("dmax_dcur", delay_cur, 63);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, i);
      chk("dmax_ov", out_valid, (i >= 64) ? 1 : 0);
      if (i >= 64) chk("dmax_data", out_data, i - 64);
      if (i == 150) chk("dmax_s150", out_data, 86);
    end
    delay_sel = 3;
    cyc(1'b0, 0);
    for (int i = 0; i < 20; i++) cyc(1'b1, i);
    chk("chg_pre", out_data, 15);
    delay_sel = 1;
    cyc(1'b1, 20);
    chk("chg_fill", filling, 1);
    chk("chg_ov", out_valid, 0);
    chk("chg_dcur", delay_cur, 1);
    chk("chg_hold", out_data, 15);
    cyc(1'b1, 21);
    chk("chg_ov21", out_valid, 0);
    cyc(1'b1, 22);
    chk("chg_ov22", out_valid, 1);
    chk("chg_data22", out_data, 20);
    chk("chg_run", filling, 0);
    cyc(1'b1, 23);
    chk("chg_data23", out_data, 21);
    flush = 1'b1;
    cyc(1'b1, 30);
    flush = 1'b0;
    chk("fl_fill", filling, 1);
    chk("fl_ov", out_valid, 0);
    chk("fl_dcur", delay_cur, 1);
    cyc(1'b1, 31);
    chk("fl_ov31", out_valid, 0);
    cyc(1'b1, 32);
    chk("fl_ov32", out_valid, 1);
    chk("fl_data32", out_data, 30);
    cyc(1'b0, 0);
    chk("idle_ov", out_valid, 0);
    chk("idle_hold", out_data, 30);
    delay_sel = 0;
    cyc(1'b0, 0);
    cyc(1'b1, 16383);
    chk("ovr_ov0", out_valid, 0);
    cyc(1'b1, 5);
    chk("ovr_d0", out_data, 16383);
`ifdef ADC_SAMPLE_DELAY_OVR_EN
    chk("ovr_f0", ovr_out, 1);
`endif
    cyc(1'b1, 0);
    chk("ovr_d1", out_data, 5);
`ifdef ADC_SAMPLE_DELAY_OVR_EN
    chk("ovr_f1", ovr_out, 0);
`endif
    cyc(1'b1, 7);
    chk("ovr_d2", out_data, 0);
`ifdef ADC_SAMPLE_DELAY_OVR_EN
    chk("ovr_f2", ovr_out, 1);
`endif
    cyc(1'b1, 9);
    chk("pre_rst", out_data, 7);
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_fill", filling, 1);
    chk("mrst_dcur", delay_cur, 0);
    cyc(1'b1, 3);
    rst_n = 1'b1;
    cyc(1'b1, 1);
    chk("mrst_ov1", out_valid, 0);
    cyc(1'b1, 2);
    chk("mrst_ov2", out_valid, 1);
    chk("mrst_data2", out_data, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
